dxm_mux_reg: RTL and testbench

DXM_MUX_REG -- requirements
Module: dxm_mux_reg

---
 rtl/dxm_mux_reg_pkg.sv | 30 +++
 rtl/dxm_mux_reg_if.sv | 40 ++++
 rtl/dxm_mux_blank_cnt.sv | 34 +++
 rtl/dxm_mux_reg.sv | 119 +++++++++++
 tb/tb_dxm_mux_reg.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dxm_mux_reg_pkg.sv
// ---------------------------------------------------------------------------
// dxm_mux_reg_pkg
// Shared definitions for the registered channel multiplexer: FSM state
// encoding, legal parameter limits, blanking counter width and a helper that
// computes the select width a given channel count requires.
// No ports (package).
// ---------------------------------------------------------------------------
package dxm_mux_reg_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } dxm_state_e;

    localparam int NUM_CH_MIN    = 2;
    localparam int NUM_CH_MAX    = 16;
    localparam int BLANK_CYC_MAX = 15;
    localparam int CNT_W         = 4;

    // ceil(log2(n)), never less than 1
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dxm_mux_reg_if.sv
// ---------------------------------------------------------------------------
// dxm_mux_reg_if
// Bundles the channel inputs, select request and registered outputs of
// dxm_mux_reg.
//   in_data   : packed channel data, channel k at [k*mux_width +: mux_width]
//   in_valid  : per-channel valid
//   sel       : requested channel index
//   sel_upd   : single-cycle strobe that loads sel
//   out       : registered selected data
//   out_valid : registered qualifier for out
//   cur_sel   : currently active channel
//   busy      : high while a switch is blanking
//   sel_err   : one-cycle pulse on an out-of-range request
// master drives the requests/data, slave is the multiplexer.
// ---------------------------------------------------------------------------
interface dxm_mux_reg_if #(
    parameter int mux_width = 1,
    parameter int num_ch    = 4,
    parameter int sel_w     = 2
);
    logic [num_ch*mux_width-1:0] in_data;
    logic [num_ch-1:0]           in_valid;
    logic [sel_w-1:0]            sel;
    logic                        sel_upd;
    logic [mux_width-1:0]        out;
    logic                        out_valid;
    logic [sel_w-1:0]            cur_sel;
    logic                        busy;
    logic                        sel_err;

    modport master (
        output in_data, in_valid, sel, sel_upd,
        input  out, out_valid, cur_sel, busy, sel_err
    );

    modport slave (
        input  in_data, in_valid, sel, sel_upd,
        output out, out_valid, cur_sel, busy, sel_err
    );
endinterface

// File: rtl/dxm_mux_blank_cnt.sv
// ---------------------------------------------------------------------------
// dxm_mux_blank_cnt
// Blanking down-counter. Load has priority over decrement; the count
// saturates at zero instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val
//   load_val   : value to load
//   dec        : decrement by one when non-zero
//   zero       : count is zero
// ---------------------------------------------------------------------------
module dxm_mux_blank_cnt
    import dxm_mux_reg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dxm_mux_reg.sv
// ---------------------------------------------------------------------------
// dxm_mux_reg
// Registered N:1 channel multiplexer with output blanking after a channel
// switch. In ACTIVE the selected channel is registered to the output with one
// cycle of latency. A switch to a different in-range channel blanks the
// output (out_valid low, out held) for blank_cyc cycles. Out-of-range
// requests are ignored and flagged with a one-cycle sel_err pulse.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dxm_mux_reg_if slave (data/valid in, select request, outputs)
// ---------------------------------------------------------------------------
module dxm_mux_reg
    import dxm_mux_reg_pkg::*;
#(
    parameter int mux_width = 1,
    parameter int num_ch    = 4,
    parameter int blank_cyc = 2,
    parameter int sel_w     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dxm_mux_reg_if.slave  bus
);

    if ((num_ch < NUM_CH_MIN) || (num_ch > NUM_CH_MAX)) begin : g_bad_num_ch
        $error("dxm_mux_reg: num_ch out of legal range");
    end
    if ((blank_cyc < 0) || (blank_cyc > BLANK_CYC_MAX)) begin : g_bad_blank_cyc
        $error("dxm_mux_reg: blank_cyc out of legal range");
    end
    if (sel_w != sel_width(num_ch)) begin : g_bad_sel_w
        $error("dxm_mux_reg: sel_w does not match num_ch");
    end

    localparam logic [sel_w:0]     NUM_CH_EXT = (sel_w + 1)'(num_ch);
    localparam logic [CNT_W-1:0]   BLANK_LOAD = (blank_cyc > 0) ? CNT_W'(blank_cyc - 1) : '0;

    dxm_state_e           state, state_nxt;
    logic [sel_w-1:0]     cur_sel, cur_sel_nxt;
    logic [mux_width-1:0] out_p1;
    logic                 vld_p1;
    logic                 err_p1;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic                 sel_in_range, req_sw, req_bad;

    assign sel_in_range = ({1'b0, bus.sel} < NUM_CH_EXT);
    assign req_sw       = bus.sel_upd && sel_in_range && (bus.sel != cur_sel);
    assign req_bad      = bus.sel_upd && !sel_in_range;

    dxm_mux_blank_cnt u_blank_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (BLANK_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt   = state;
        cur_sel_nxt = cur_sel;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state)
            ST_ACTIVE: begin
                if (req_sw) begin
                    cur_sel_nxt = bus.sel;
                    if (blank_cyc > 0) begin
                        state_nxt = ST_BLANK;
                        cnt_load  = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                // a new switch mid-blank restarts the full blanking window
                if (req_sw) begin
                    cur_sel_nxt = bus.sel;
                    cnt_load    = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // ---- stage p1: state, selection and output registers ----
    // The output follows the next state so that blanking begins on the same
    // edge that accepts the switch, and the new channel appears on the edge
    // that leaves BLANK (or immediately when there is no blanking).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACTIVE;
            cur_sel <= '0;
            out_p1  <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_sel <= cur_sel_nxt;
            err_p1  <= req_bad;
            if (state_nxt == ST_ACTIVE) begin
                out_p1 <= bus.in_data[int'(cur_sel_nxt) * mux_width +: mux_width];
                vld_p1 <= bus.in_valid[cur_sel_nxt];
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;
    assign bus.cur_sel   = cur_sel;
    assign bus.busy      = (state == ST_BLANK);
    assign bus.sel_err   = err_p1;

endmodule

// File: tb/tb_dxm_mux_reg.sv
module tb_dxm_mux_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dxm_mux_reg_if #(.mux_width(4), .num_ch(4), .sel_w(2)) if_a ();
    dxm_mux_reg_if #(.mux_width(4), .num_ch(4), .sel_w(2)) if_b ();
    dxm_mux_reg_if #(.mux_width(4), .num_ch(5), .sel_w(3)) if_c ();

    dxm_mux_reg #(.mux_width(4), .num_ch(4), .blank_cyc(2), .sel_w(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    dxm_mux_reg #(.mux_width(4), .num_ch(4), .blank_cyc(0), .sel_w(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    dxm_mux_reg #(.mux_width(4), .num_ch(5), .blank_cyc(2), .sel_w(3)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        upd;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  vld;
        logic [3:0]  e_out;
        logic        e_ov;
        logic [1:0]  e_cur;
        logic        e_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check_reset(input string tag);
        check({tag, "_a_out"},  32'(if_a.out), 0);
        check({tag, "_a_ov"},   32'(if_a.out_valid), 0);
        check({tag, "_a_cur"},  32'(if_a.cur_sel), 0);
        check({tag, "_a_busy"}, 32'(if_a.busy), 0);
        check({tag, "_a_err"},  32'(if_a.sel_err), 0);
        check({tag, "_b_out"},  32'(if_b.out), 0);
        check({tag, "_c_ov"},   32'(if_c.out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // upd, sel, data, vld -> out, out_valid, cur_sel, busy
        vecs[0]  = '{1'b0, 2'd0, 16'hDCBA, 4'hF, 4'hA, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 16'hDCB5, 4'hF, 4'h5, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 16'hDCBA, 4'hE, 4'hA, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 16'hDCBA, 4'hF, 4'hA, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 16'hDCBA, 4'hF, 4'hA, 1'b0, 2'd2, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 16'hDCBA, 4'hF, 4'hA, 1'b0, 2'd2, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 16'hDCBA, 4'hF, 4'hC, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 16'hD7BA, 4'hF, 4'h7, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 16'hDCBA, 4'hF, 4'h7, 1'b0, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, 2'd3, 16'hDCBA, 4'hF, 4'h7, 1'b0, 2'd3, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 16'hDCBA, 4'hF, 4'h7, 1'b0, 2'd3, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 16'hDCBA, 4'hF, 4'hD, 1'b1, 2'd3, 1'b0};

        if_a.in_data = 16'hDCBA; if_a.in_valid = 4'hF; if_a.sel = '0; if_a.sel_upd = 1'b0;
        if_b.in_data = 16'hDCBA; if_b.in_valid = 4'hF; if_b.sel = '0; if_b.sel_upd = 1'b0;
        if_c.in_data = 20'hEDCBA; if_c.in_valid = 5'h1F; if_c.sel = '0; if_c.sel_upd = 1'b0;

        // reset held across clock edges
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;

        // table-driven vectors on the blank_cyc=2 instance
        for (int i = 0; i < 12; i++) begin
            if_a.sel_upd  = vecs[i].upd;
            if_a.sel      = vecs[i].sel;
            if_a.in_data  = vecs[i].data;
            if_a.in_valid = vecs[i].vld;
            tick();
            check($sformatf("vec%0d_out", i),  32'(if_a.out),       32'(vecs[i].e_out));
            check($sformatf("vec%0d_ov", i),   32'(if_a.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_cur", i),  32'(if_a.cur_sel),   32'(vecs[i].e_cur));
            check($sformatf("vec%0d_busy", i), 32'(if_a.busy),      32'(vecs[i].e_busy));
            check($sformatf("vec%0d_err", i),  32'(if_a.sel_err),   0);
        end
        if_a.sel_upd = 1'b0;

        // blank_cyc=0 instance: immediate switch, no blanking
        if_b.sel = 2'd3; if_b.sel_upd = 1'b1;
        tick();
        if_b.sel_upd = 1'b0;
        check("b_sw_busy", 32'(if_b.busy), 0);
        check("b_sw_out",  32'(if_b.out), 32'hD);
        check("b_sw_ov",   32'(if_b.out_valid), 1);
        check("b_sw_cur",  32'(if_b.cur_sel), 3);
        tick();
        check("b_hold_busy", 32'(if_b.busy), 0);
        check("b_hold_out",  32'(if_b.out), 32'hD);

        // five-channel instance: out-of-range request while active
        if_c.sel = 3'd5; if_c.sel_upd = 1'b1;
        tick();
        if_c.sel_upd = 1'b0;
        check("c_err_pulse", 32'(if_c.sel_err), 1);
        check("c_err_cur",   32'(if_c.cur_sel), 0);
        check("c_err_out",   32'(if_c.out), 32'hA);
        check("c_err_ov",    32'(if_c.out_valid), 1);
        check("c_err_busy",  32'(if_c.busy), 0);
        tick();
        check("c_err_clear", 32'(if_c.sel_err), 0);
        check("c_err_ov2",   32'(if_c.out_valid), 1);

        // highest legal channel, then an illegal request during blanking
        if_c.sel = 3'd4; if_c.sel_upd = 1'b1;
        tick();
        check("c_sw4_busy", 32'(if_c.busy), 1);
        check("c_sw4_cur",  32'(if_c.cur_sel), 4);
        check("c_sw4_ov",   32'(if_c.out_valid), 0);
        if_c.sel = 3'd7;
        tick();
        if_c.sel_upd = 1'b0;
        check("c_blk_err",  32'(if_c.sel_err), 1);
        check("c_blk_cur",  32'(if_c.cur_sel), 4);
        check("c_blk_busy", 32'(if_c.busy), 1);
        for (int k = 0; k < 8 && if_c.busy; k++) tick();
        check("c_blk_done", 32'(if_c.busy), 0);
        check("c_final_out", 32'(if_c.out), 32'hE);
        check("c_final_ov",  32'(if_c.out_valid), 1);
        check("c_final_err", 32'(if_c.sel_err), 0);

        // reset during the first blank cycle aborts the switch
        if_a.in_data = 16'hDCBA; if_a.in_valid = 4'hF;
        if_a.sel = 2'd1; if_a.sel_upd = 1'b1;
        tick();
        if_a.sel_upd = 1'b0;
        check("a_pre_rst_busy", 32'(if_a.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("a_post_out",  32'(if_a.out), 32'hA);
        check("a_post_ov",   32'(if_a.out_valid), 1);
        check("a_post_cur",  32'(if_a.cur_sel), 0);
        check("a_post_busy", 32'(if_a.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
